// File: rtl/shot_pkg.sv
// Shared definitions for the shot engine: state encoding, Q-format width
// helper and the integer clamp used for velocities and pixel coordinates.
package shot_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLIGHT = 3'd1,
    S_SCORED = 3'd2,
    S_MISS   = 3'd3
  } shot_state_t;

  localparam int COORD_W_DEFAULT = 10;
  localparam int FRAC_W_DEFAULT  = 6;

  // Two guard bits above the integer part keep off-screen positions and
  // full-scale velocities representable without wrap.
  function automatic int q_width(input int coord_w, input int frac_w);
    return coord_w + frac_w + 2;
  endfunction

  localparam int W = q_width(COORD_W_DEFAULT, FRAC_W_DEFAULT);

  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    else if (v > hi) return hi;
    else return v;
  endfunction

endpackage

// File: rtl/shot_step.sv
// Combinational single-frame motion step: next position/velocity, hoop and
// boundary detection on the new position, and clamped pixel coordinates.
module shot_step
  import shot_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int FRAC_W      = 6,
  parameter int GRAVITY     = 16,
  parameter int HOOP_X      = 540,
  parameter int HOOP_Y      = 200,
  parameter int HOOP_HALF_W = 12,
  parameter int FLOOR_Y     = 470,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  localparam int QW         = q_width(COORD_W, FRAC_W)
) (
  input  logic signed [QW-1:0]      px,
  input  logic signed [QW-1:0]      py,
  input  logic signed [QW-1:0]      vx,
  input  logic signed [QW-1:0]      vy,
  output logic signed [QW-1:0]      px_next,
  output logic signed [QW-1:0]      py_next,
  output logic signed [QW-1:0]      vy_next,
  output logic                      hoop_hit,
  output logic                      bound_hit,
  output logic        [COORD_W-1:0] pix_x,
  output logic        [COORD_W-1:0] pix_y
);

  localparam int HOOP_Y_Q = HOOP_Y << FRAC_W;

  int nx, ny, nx_pix, ny_pix, dx;

  // All three updates use the pre-step values; py is therefore the
  // "previous" height against which the downward hoop crossing is judged.
  always_comb begin
    nx        = int'(px) + int'(vx);
    ny        = int'(py) + int'(vy);
    nx_pix    = nx >>> FRAC_W;
    ny_pix    = ny >>> FRAC_W;
    dx        = nx_pix - HOOP_X;
    px_next   = QW'(nx);
    py_next   = QW'(ny);
    vy_next   = QW'(int'(vy) + GRAVITY);
    hoop_hit  = (int'(py) < HOOP_Y_Q) && (ny >= HOOP_Y_Q) && (int'(vy) > 0) &&
                (dx >= -HOOP_HALF_W) && (dx <= HOOP_HALF_W);
    bound_hit = (ny_pix >= FLOOR_Y) || (nx < 0) || (nx_pix >= SCREEN_W);
    pix_x     = COORD_W'(clamp_int(nx_pix, 0, SCREEN_W - 1));
    pix_y     = COORD_W'(clamp_int(ny_pix, 0, SCREEN_H - 1));
  end

endmodule

// File: rtl/shot_engine.sv
// Shot lifecycle controller: launch from accelerometer counts, frame-stepped
// flight, made/miss resolution, result hold and saturating score.
module shot_engine
  import shot_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int FRAC_W      = 6,
  parameter int VEL_SHIFT   = 4,
  parameter int VMAX        = 1023,
  parameter int GRAVITY     = 16,
  parameter int LAUNCH_X    = 80,
  parameter int LAUNCH_Y    = 400,
  parameter int HOOP_X      = 540,
  parameter int HOOP_Y      = 200,
  parameter int HOOP_HALF_W = 12,
  parameter int FLOOR_Y     = 470,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int HOLD_FRAMES = 60,
  localparam int QW         = q_width(COORD_W, FRAC_W)
) (
  input  logic                CLK100MHZ,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic                shoot,
  input  logic signed [15:0]  ax,
  input  logic signed [15:0]  ay,
  output logic [COORD_W-1:0]  ball_x,
  output logic [COORD_W-1:0]  ball_y,
  output logic                in_flight,
  output logic                made,
  output logic                missed,
  output logic [7:0]          score,
  output logic [2:0]          state
);

  localparam logic signed [QW-1:0] PX0 = QW'(LAUNCH_X << FRAC_W);
  localparam logic signed [QW-1:0] PY0 = QW'(LAUNCH_Y << FRAC_W);
  localparam logic [COORD_W-1:0]   BX0 = COORD_W'(clamp_int(LAUNCH_X, 0, SCREEN_W - 1));
  localparam logic [COORD_W-1:0]   BY0 = COORD_W'(clamp_int(LAUNCH_Y, 0, SCREEN_H - 1));
  localparam int                   HC_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [HC_W-1:0]      HOLD_LAST = HC_W'(HOLD_FRAMES - 1);

  shot_state_t               state_reg;
  logic signed [QW-1:0]      px_reg, py_reg, vx_reg, vy_reg;
  logic [HC_W-1:0]           hold_reg;
  logic [7:0]                score_reg;
  logic                      made_reg, missed_reg, in_flight_reg;
  logic [COORD_W-1:0]        ball_x_reg, ball_y_reg;

  logic signed [QW-1:0]      px_next, py_next, vy_next;
  logic signed [QW-1:0]      launch_vx, launch_vy;
  logic                      hoop_hit, bound_hit;
  logic [COORD_W-1:0]        pix_x, pix_y;

  shot_step #(
    .COORD_W     (COORD_W),
    .FRAC_W      (FRAC_W),
    .GRAVITY     (GRAVITY),
    .HOOP_X      (HOOP_X),
    .HOOP_Y      (HOOP_Y),
    .HOOP_HALF_W (HOOP_HALF_W),
    .FLOOR_Y     (FLOOR_Y),
    .SCREEN_W    (SCREEN_W),
    .SCREEN_H    (SCREEN_H)
  ) u_step (
    .px        (px_reg),
    .py        (py_reg),
    .vx        (vx_reg),
    .vy        (vy_reg),
    .px_next   (px_next),
    .py_next   (py_next),
    .vy_next   (vy_next),
    .hoop_hit  (hoop_hit),
    .bound_hit (bound_hit),
    .pix_x     (pix_x),
    .pix_y     (pix_y)
  );

  // Launch velocity: scale accel counts down, flip y so tilting up throws up,
  // and clamp the magnitude.
  always_comb begin
    launch_vx = QW'(clamp_int(int'(ax) >>> VEL_SHIFT, -VMAX, VMAX));
    launch_vy = QW'(clamp_int(-(int'(ay) >>> VEL_SHIFT), -VMAX, VMAX));
  end

  // Shot FSM with registered outputs; result pulses default low every cycle.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      px_reg        <= PX0;
      py_reg        <= PY0;
      vx_reg        <= '0;
      vy_reg        <= '0;
      hold_reg      <= '0;
      score_reg     <= '0;
      made_reg      <= 1'b0;
      missed_reg    <= 1'b0;
      in_flight_reg <= 1'b0;
      ball_x_reg    <= BX0;
      ball_y_reg    <= BY0;
    end else begin
      made_reg   <= 1'b0;
      missed_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          px_reg <= PX0;
          py_reg <= PY0;
          // A coincident frame_tick is deliberately ignored: launch only.
          if (shoot) begin
            vx_reg        <= launch_vx;
            vy_reg        <= launch_vy;
            state_reg     <= S_FLIGHT;
            in_flight_reg <= 1'b1;
          end
        end
        S_FLIGHT: begin
          if (frame_tick) begin
            px_reg     <= px_next;
            py_reg     <= py_next;
            vy_reg     <= vy_next;
            ball_x_reg <= pix_x;
            ball_y_reg <= pix_y;
            hold_reg   <= '0;
            // Hoop is checked first so a simultaneous floor hit still scores.
            if (hoop_hit) begin
              state_reg     <= S_SCORED;
              in_flight_reg <= 1'b0;
              made_reg      <= 1'b1;
              if (score_reg != 8'hFF) score_reg <= score_reg + 8'd1;
            end else if (bound_hit) begin
              state_reg     <= S_MISS;
              in_flight_reg <= 1'b0;
              missed_reg    <= 1'b1;
            end
          end
        end
        S_SCORED, S_MISS: begin
          if (frame_tick) begin
            if (hold_reg == HOLD_LAST) begin
              hold_reg   <= '0;
              state_reg  <= S_IDLE;
              px_reg     <= PX0;
              py_reg     <= PY0;
              ball_x_reg <= BX0;
              ball_y_reg <= BY0;
            end else begin
              hold_reg <= hold_reg + HC_W'(1);
            end
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          in_flight_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ball_x    = ball_x_reg;
  assign ball_y    = ball_y_reg;
  assign in_flight = in_flight_reg;
  assign made      = made_reg;
  assign missed    = missed_reg;
  assign score     = score_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_shot_engine.sv
// Bench for shot_engine: two instances (default hoop, and a hoop placed on
// the straight-drop path) share stimulus; a behavioural model predicts each
// cycle's outputs into a queue that a posedge monitor drains and compares.
module tb_shot_engine;

  localparam int FW = 6, VS = 4, VMAX = 1023, GRAV = 16;
  localparam int LX = 80, LY = 400, HW = 12, FLOOR = 470;
  localparam int SW = 640, SH = 480, HOLD = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic shoot = 1'b0;
  logic signed [15:0] ax = '0;
  logic signed [15:0] ay = '0;

  logic [9:0] a_bx, a_by, b_bx, b_by;
  logic a_if, a_made, a_missed, b_if, b_made, b_missed;
  logic [7:0] a_score, b_score;
  logic [2:0] a_state, b_state;

  always #5 clk = ~clk;

  shot_engine u_a (
    .CLK100MHZ(clk), .rst_n(rst_n), .frame_tick(frame_tick), .shoot(shoot),
    .ax(ax), .ay(ay), .ball_x(a_bx), .ball_y(a_by), .in_flight(a_if),
    .made(a_made), .missed(a_missed), .score(a_score), .state(a_state)
  );

  shot_engine #(.HOOP_X(80), .HOOP_Y(420)) u_b (
    .CLK100MHZ(clk), .rst_n(rst_n), .frame_tick(frame_tick), .shoot(shoot),
    .ax(ax), .ay(ay), .ball_x(b_bx), .ball_y(b_by), .in_flight(b_if),
    .made(b_made), .missed(b_missed), .score(b_score), .state(b_state)
  );

  typedef struct {
    int bx; int by; int st; int inf; int made; int missed; int score;
  } obs_t;
  typedef struct { int k; int cyc; obs_t o; } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int b_made_cnt = 0;

  // Reference model state, in pixels scaled by 2^FW, one slot per instance.
  int hx[2] = '{540, 80};
  int hy[2] = '{200, 420};
  int m_st[2], m_px[2], m_py[2], m_vx[2], m_vy[2], m_hold[2], m_score[2];
  int m_made[2], m_missed[2];

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model_reset(input int k);
    m_st[k] = 0; m_px[k] = LX * 64; m_py[k] = LY * 64;
    m_vx[k] = 0; m_vy[k] = 0; m_hold[k] = 0; m_score[k] = 0;
    m_made[k] = 0; m_missed[k] = 0;
  endfunction

  function automatic void model_step(input int k, input bit sh, input bit tk,
                                     input int xa, input int ya);
    int nx, ny;
    m_made[k] = 0;
    m_missed[k] = 0;
    if (m_st[k] == 0) begin
      if (sh) begin
        m_vx[k] = clampi(xa / 16 - ((xa < 0 && xa % 16 != 0) ? 1 : 0), -VMAX, VMAX);
        m_vy[k] = clampi(-(ya / 16 - ((ya < 0 && ya % 16 != 0) ? 1 : 0)), -VMAX, VMAX);
        m_st[k] = 1;
      end
    end else if (m_st[k] == 1) begin
      if (tk) begin
        nx = m_px[k] + m_vx[k];
        ny = m_py[k] + m_vy[k];
        if (m_py[k] < hy[k] * 64 && ny >= hy[k] * 64 && m_vy[k] > 0 &&
            absi($floor(real'(nx) / 64.0) - hy[k] * 0 - hx[k]) <= HW) begin
          m_st[k] = 2; m_made[k] = 1; m_hold[k] = 0;
          if (m_score[k] < 255) m_score[k]++;
        end else if ($floor(real'(ny) / 64.0) >= FLOOR || nx < 0 ||
                     $floor(real'(nx) / 64.0) >= SW) begin
          m_st[k] = 3; m_missed[k] = 1; m_hold[k] = 0;
        end
        m_px[k] = nx;
        m_py[k] = ny;
        m_vy[k] = m_vy[k] + GRAV;
      end
    end else begin
      if (tk) begin
        m_hold[k]++;
        if (m_hold[k] == HOLD) begin
          m_st[k] = 0; m_hold[k] = 0; m_px[k] = LX * 64; m_py[k] = LY * 64;
        end
      end
    end
  endfunction

  function automatic obs_t model_obs(input int k);
    obs_t o;
    o.bx = clampi(int'($floor(real'(m_px[k]) / 64.0)), 0, SW - 1);
    o.by = clampi(int'($floor(real'(m_py[k]) / 64.0)), 0, SH - 1);
    o.st = m_st[k];
    o.inf = (m_st[k] == 1) ? 1 : 0;
    o.made = m_made[k];
    o.missed = m_missed[k];
    o.score = m_score[k];
    return o;
  endfunction

  function automatic obs_t get_obs(input int k);
    obs_t o;
    if (k == 0) begin
      o.bx = int'(a_bx); o.by = int'(a_by); o.st = int'(a_state); o.inf = int'(a_if);
      o.made = int'(a_made); o.missed = int'(a_missed); o.score = int'(a_score);
    end else begin
      o.bx = int'(b_bx); o.by = int'(b_by); o.st = int'(b_state); o.inf = int'(b_if);
      o.made = int'(b_made); o.missed = int'(b_missed); o.score = int'(b_score);
    end
    return o;
  endfunction

  function automatic bit same(input obs_t x, input obs_t y);
    return x.bx == y.bx && x.by == y.by && x.st == y.st && x.inf == y.inf &&
           x.made == y.made && x.missed == y.missed && x.score == y.score;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Drive one cycle of stimulus and push the predicted post-edge outputs.
  task automatic drive(input bit rst, input bit sh, input bit tk,
                       input logic signed [15:0] x, input logic signed [15:0] y);
    exp_t e;
    bit falling;
    @(negedge clk);
    cyc++;
    falling = (rst_n == 1'b1) && !rst;
    rst_n = rst; shoot = sh; frame_tick = tk; ax = x; ay = y;
    for (int k = 0; k < 2; k++) begin
      if (!rst) model_reset(k);
      else model_step(k, sh, tk, int'(x), int'(y));
      e.k = k; e.cyc = cyc; e.o = model_obs(k);
      sb.push_back(e);
    end
    if (falling) begin
      #1;
      chk("async_rst_a_state", int'(a_state), 0);
      chk("async_rst_b_score", int'(b_score), 0);
      chk("async_rst_b_inflight", int'(b_if), 0);
      chk("async_rst_a_by", int'(a_by), LY);
    end
  endtask

  // Monitor: after each active edge, compare every pending prediction.
  always @(posedge clk) begin
    #2;
    while (sb.size() > 0) begin
      exp_t e;
      obs_t a;
      e = sb.pop_front();
      a = get_obs(e.k);
      checks++;
      if (!same(a, e.o)) begin
        errors++;
        if (errors <= 40)
          $display("FAIL dut%0d cyc%0d got bx=%0d by=%0d st=%0d fl=%0d mk=%0d ms=%0d sc=%0d expected bx=%0d by=%0d st=%0d fl=%0d mk=%0d ms=%0d sc=%0d",
                   e.k, e.cyc, a.bx, a.by, a.st, a.inf, a.made, a.missed, a.score,
                   e.o.bx, e.o.by, e.o.st, e.o.inf, e.o.made, e.o.missed, e.o.score);
      end
      checks++;
      if (a.bx > SW - 1 || a.by > SH - 1) begin
        errors++;
        $display("FAIL dut%0d screen_bound got bx=%0d by=%0d limit 639/479", e.k, a.bx, a.by);
      end
      if (a.made == 1) begin
        if (e.k == 1) b_made_cnt++;
        $display("shot dut%0d made score=%0d cycle=%0d", e.k, a.score, e.cyc);
      end
      if (a.missed == 1)
        $display("shot dut%0d missed at x=%0d y=%0d cycle=%0d", e.k, a.bx, a.by, e.cyc);
    end
  end

  initial begin
    int made0;
    // Reset held with activity on the inputs.
    repeat (4) drive(1'b0, 1'b1, 1'b1, 16'sh1234, 16'sh4321);
    chk("rst_ball_x", int'(a_bx), 80);
    chk("rst_ball_y", int'(a_by), 400);
    chk("rst_state", int'(a_state), 0);
    chk("rst_score", int'(a_score), 0);
    chk("rst_inflight", int'(a_if), 0);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 16'sh0, 16'sh0);

    // Straight drop; shoot coincident with frame_tick launches without a step.
    drive(1'b1, 1'b1, 1'b1, 16'sh0, 16'sh0);
    for (int i = 1; i <= 90; i++) begin
      drive(1'b1, (i == 5 || i == 20), 1'b1, 16'sh7FFF, 16'sh8000);
      if (i == 1) begin
        chk("launch_state", int'(a_state), 1);
        chk("launch_inflight", int'(a_if), 1);
        chk("launch_no_step_y", int'(a_by), 400);
      end
      if (i == 14) begin
        chk("drop_t13_a_y", int'(a_by), 419);
        chk("drop_t13_b_y", int'(b_by), 419);
      end
      if (i == 15) begin
        chk("hoop_made", int'(b_made), 1);
        chk("hoop_y", int'(b_by), 422);
        chk("hoop_score", int'(b_score), 1);
        chk("hoop_state", int'(b_state), 2);
      end
      if (i == 26) begin
        chk("floor_missed", int'(a_missed), 1);
        chk("floor_y", int'(a_by), 475);
        chk("floor_state", int'(a_state), 3);
        chk("hoop_no_miss", int'(b_missed), 0);
      end
      if (i == 85) chk("hold_t84_state", int'(a_state), 3);
      if (i == 86) begin
        chk("hold_done_state", int'(a_state), 0);
        chk("hold_done_x", int'(a_bx), 80);
        chk("hold_done_y", int'(a_by), 400);
      end
    end

    // Full-scale launch downward: both velocities clamp, ball hits the floor.
    drive(1'b1, 1'b1, 1'b0, 16'sh7FFF, 16'sh8000);
    for (int i = 1; i <= 70; i++) begin
      drive(1'b1, 1'b0, 1'b1, 16'sh0, 16'sh0);
      if (i == 6) begin
        chk("clamp_floor_missed", int'(a_missed), 1);
        chk("clamp_floor_y", int'(a_by), 479);
        chk("clamp_floor_x", int'(a_bx), 159);
      end
    end

    // Full-scale launch upward-right: exits the right wall.
    drive(1'b1, 1'b1, 1'b0, 16'sh7FFF, 16'sh7FFF);
    for (int i = 1; i <= 100; i++) begin
      drive(1'b1, 1'b0, 1'b1, 16'sh0, 16'sh0);
      if (i == 36) begin
        chk("wall_t35_x", int'(a_bx), 639);
        chk("wall_t35_state", int'(a_state), 1);
      end
      if (i == 37) begin
        chk("wall_missed", int'(a_missed), 1);
        chk("wall_x", int'(a_bx), 639);
        chk("wall_state", int'(a_state), 3);
      end
    end

    // Reset asserted mid-flight.
    drive(1'b1, 1'b1, 1'b0, 16'sh0100, 16'sh0200);
    repeat (10) drive(1'b1, 1'b0, 1'b1, 16'sh0, 16'sh0);
    drive(1'b0, 1'b0, 1'b1, 16'sh0, 16'sh0);
    drive(1'b0, 1'b1, 1'b1, 16'sh0, 16'sh0);

    // Randomised traffic, including occasional one-cycle resets.
    for (int n = 0; n < 3000; n++)
      drive(($urandom_range(0, 499) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 1) == 1), 16'($urandom), 16'($urandom));

    // Score saturation: back-to-back made shots on the hoop instance.
    drive(1'b0, 1'b0, 1'b0, 16'sh0, 16'sh0);
    made0 = b_made_cnt;
    for (int n = 0; n < 19300; n++)
      drive(1'b1, 1'b1, 1'b1, 16'sh0, 16'sh0);
    drive(1'b1, 1'b0, 1'b0, 16'sh0, 16'sh0);
    chk("sat_score", int'(b_score), 255);
    chk("sat_made_count_ge_256", (b_made_cnt - made0 >= 256) ? 1 : 0, 1);

    repeat (3) drive(1'b1, 1'b0, 1'b0, 16'sh0, 16'sh0);
    @(posedge clk);
    #4;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
